// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Two-port (fetch / data) arbiter onto one shared memory port,
//            one outstanding transaction. Optional MEM_ARB_ROUND_ROBIN_EN
//            macro switches contested grants from D-priority to alternating.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    i_req_valid,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    output logic                    i_addr_ok,
    output logic                    i_data_ok,
    output logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    d_req_valid,
    input  logic                    d_req_write,
    input  logic [ADDR_WIDTH-1:0]   d_req_addr,
    input  logic [DATA_WIDTH/8-1:0] d_req_strobe,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    output logic                    d_addr_ok,
    output logic                    d_data_ok,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    m_req_valid,
    output logic                    m_req_write,
    output logic [ADDR_WIDTH-1:0]   m_req_addr,
    output logic [DATA_WIDTH/8-1:0] m_req_strobe,
    output logic [DATA_WIDTH-1:0]   m_req_wdata,
    input  logic                    m_addr_ok,
    input  logic                    m_data_ok,
    input  logic [DATA_WIDTH-1:0]   m_data
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_addr = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_grant_d;      // 1 = data port granted, 0 = fetch
    logic                  w_grant_nxt;
    logic                  w_grant_sel_d;
    logic                  w_any_req;
    logic                  w_req_valid;
    logic                  w_addr_ok;
    logic                  w_data_ok;
    logic [DATA_WIDTH-1:0] w_data;

    assign w_any_req   = i_req_valid | d_req_valid;
    assign w_req_valid = r_grant_d ? d_req_valid : i_req_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_grant_d;

    // Contested grant goes to whoever was not granted last time.
    assign w_grant_sel_d = (i_req_valid & d_req_valid) ? ~r_last_grant_d : d_req_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_grant_d <= 1'b0;
        end else if (r_state == c_st_idle && w_any_req) begin
            r_last_grant_d <= w_grant_sel_d;
        end
    end
`else
    assign w_grant_sel_d = d_req_valid;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= c_st_idle;
            r_grant_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant_d <= w_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant_d;
        w_addr_ok    = 1'b0;
        w_data_ok    = 1'b0;
        w_data       = '0;
        m_req_valid  = 1'b0;
        m_req_write  = 1'b0;
        m_req_addr   = '0;
        m_req_strobe = '0;
        m_req_wdata  = '0;
        case (r_state)
            c_st_idle: begin
                if (w_any_req) begin
                    w_grant_nxt = w_grant_sel_d;
                    w_state_nxt = c_st_addr;
                end
            end
            c_st_addr: begin
                m_req_valid = w_req_valid;
                m_req_addr  = r_grant_d ? d_req_addr : i_req_addr;
                if (r_grant_d) begin
                    m_req_write  = d_req_write;
                    m_req_strobe = d_req_strobe;
                    m_req_wdata  = d_req_wdata;
                end
                // An acceptance is only meaningful while a request is presented.
                if (w_req_valid && m_addr_ok) begin
                    w_addr_ok = 1'b1;
                    if (m_data_ok) begin
                        w_data_ok   = 1'b1;
                        w_data      = m_data;
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_state_nxt = c_st_data;
                    end
                end
            end
            c_st_data: begin
                if (m_data_ok) begin
                    w_data_ok   = 1'b1;
                    w_data      = m_data;
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign i_addr_ok = w_addr_ok & ~r_grant_d;
    assign i_data_ok = w_data_ok & ~r_grant_d;
    assign i_data    = r_grant_d ? '0 : w_data;
    assign d_addr_ok = w_addr_ok & r_grant_d;
    assign d_data_ok = w_data_ok & r_grant_d;
    assign d_data    = r_grant_d ? w_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Vector-table bench for mem_port_arbiter (default 32/32 widths),
//            plus reset, spurious-response and repeated-contention sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_data;
    logic        d_req_valid, d_req_write;
    logic [31:0] d_req_addr;
    logic [3:0]  d_req_strobe;
    logic [31:0] d_req_wdata;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] d_data;
    logic        m_req_valid, m_req_write;
    logic [31:0] m_req_addr;
    logic [3:0]  m_req_strobe;
    logic [31:0] m_req_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_data;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_data(i_data),
        .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
        .d_req_strobe(d_req_strobe), .d_req_wdata(d_req_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_data(d_data),
        .m_req_valid(m_req_valid), .m_req_write(m_req_write), .m_req_addr(m_req_addr),
        .m_req_strobe(m_req_strobe), .m_req_wdata(m_req_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_data(m_data)
    );

    // Output bundle: {m_v, m_w, m_addr, m_strb, m_wdata, i_aok, i_dok, i_data, d_aok, d_dok, d_data}
    typedef logic [137:0] outs_t;

    typedef struct {
        string       name;
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic        dw;
        logic [31:0] da;
        logic [3:0]  ds;
        logic [31:0] dd;
        logic        ma;
        logic        md;
        logic [31:0] mdat;
        outs_t       exp;
    } vec_t;

    vec_t vq[$];

    function automatic outs_t mk_out(logic mv, logic mw, logic [31:0] maddr, logic [3:0] mstrb,
                                     logic [31:0] mwd, logic ia_ok, logic id_ok, logic [31:0] idat,
                                     logic da_ok, logic dd_ok, logic [31:0] ddat);
        return {mv, mw, maddr, mstrb, mwd, ia_ok, id_ok, idat, da_ok, dd_ok, ddat};
    endfunction

    function automatic outs_t zero_out();
        return mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic add(string name, logic iv, logic [31:0] ia, logic dv, logic dw, logic [31:0] da,
                       logic [3:0] ds, logic [31:0] dd, logic ma, logic md, logic [31:0] mdat,
                       outs_t exp);
        vec_t v;
        v.name = name; v.iv = iv; v.ia = ia; v.dv = dv; v.dw = dw; v.da = da; v.ds = ds;
        v.dd = dd; v.ma = ma; v.md = md; v.mdat = mdat; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic drive(logic iv, logic [31:0] ia, logic dv, logic dw, logic [31:0] da,
                         logic [3:0] ds, logic [31:0] dd, logic ma, logic md, logic [31:0] mdat);
        i_req_valid = iv; i_req_addr = ia;
        d_req_valid = dv; d_req_write = dw; d_req_addr = da; d_req_strobe = ds; d_req_wdata = dd;
        m_addr_ok = ma; m_data_ok = md; m_data = mdat;
    endtask

    task automatic check(string name, outs_t exp);
        outs_t act;
        act = {m_req_valid, m_req_write, m_req_addr, m_req_strobe, m_req_wdata,
               i_addr_ok, i_data_ok, i_data, d_addr_ok, d_data_ok, d_data};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Settle inputs a little after the edge, compare, then advance one clock.
    task automatic step(string name, outs_t exp);
        #1;
        check(name, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic apply(vec_t v);
        drive(v.iv, v.ia, v.dv, v.dw, v.da, v.ds, v.dd, v.ma, v.md, v.mdat);
        step(v.name, v.exp);
    endtask

    initial begin
        logic exp_d;

        // Reset held with live-looking inputs: everything must stay quiet.
        resetn = 1'b0;
        drive(1, 32'h100, 1, 1, 32'h200, 4'hF, 32'h1234_5678, 1, 1, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", zero_out());
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Fetch-only transaction
        add("fetch_idle",   1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, zero_out());
        add("fetch_addr",   1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0,
            mk_out(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0));
        add("fetch_addrok", 1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0,
            mk_out(1, 0, 32'h100, 0, 0, 1, 0, 0, 0, 0, 0));
        add("fetch_wait",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, zero_out());
        add("fetch_data",   0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF,
            mk_out(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0));
        add("fetch_done",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, zero_out());
        // Spurious responses in IDLE are dropped
        add("spur_dok",     0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55, zero_out());
        add("spur_aok",     0, 0, 0, 0, 0, 0, 0, 1, 0, 0, zero_out());
        // Contention: D wins, same-cycle addr/data ok, then I is served
        add("cont_idle",    1, 32'h100, 1, 1, 32'h200, 4'hF, 32'h1234_5678, 0, 0, 0, zero_out());
        add("cont_d_both",  1, 32'h100, 1, 1, 32'h200, 4'hF, 32'h1234_5678, 1, 1, 32'hCAFE_0001,
            mk_out(1, 1, 32'h200, 4'hF, 32'h1234_5678, 0, 0, 0, 1, 1, 32'hCAFE_0001));
        add("cont_i_idle",  1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, zero_out());
        add("cont_i_addr",  1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0,
            mk_out(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0));
        add("cont_i_aok",   1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0,
            mk_out(1, 0, 32'h100, 0, 0, 1, 0, 0, 0, 0, 0));
        add("data_aok_ign", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, zero_out());
        add("cont_i_data",  0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5_A5A5,
            mk_out(0, 0, 0, 0, 0, 0, 1, 32'hA5A5_A5A5, 0, 0, 0));
        add("cont_i_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, zero_out());
        // Granted D drops valid while in ADDR
        add("drop_idle",    0, 0, 1, 0, 32'h300, 0, 0, 0, 0, 0, zero_out());
        add("drop_low",     0, 0, 0, 0, 32'h300, 0, 0, 0, 0, 0,
            mk_out(0, 0, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0));
        add("drop_back",    0, 0, 1, 0, 32'h300, 0, 0, 1, 0, 0,
            mk_out(1, 0, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0));
        add("drop_data",    0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D,
            mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D));
        add("drop_done",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, zero_out());

        foreach (vq[k]) apply(vq[k]);

        // Reset while waiting in DATA, then a late data_ok after release.
        drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_seq_idle", zero_out());
        drive(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
        step("rst_seq_aok", mk_out(1, 0, 32'h100, 0, 0, 1, 0, 0, 0, 0, 0));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        resetn = 1'b0;
        #1;
        check("rst_in_data", zero_out());
        @(posedge clk);
        #1;
        resetn = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7777_7777);
        step("rst_late_dok", zero_out());
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_after", zero_out());

        // Four back-to-back contested transactions straight after reset.
        for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = (t % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            drive(1, 32'h400, 1, 0, 32'h800, 0, 0, 0, 0, 0);
            step($sformatf("rr_idle_%0d", t), zero_out());
            drive(1, 32'h400, 1, 0, 32'h800, 0, 0, 1, 1, 32'h1000 + t);
            step($sformatf("rr_grant_%0d", t),
                 exp_d ? mk_out(1, 0, 32'h800, 0, 0, 0, 0, 0, 1, 1, 32'h1000 + t)
                       : mk_out(1, 0, 32'h400, 0, 0, 1, 1, 32'h1000 + t, 0, 0, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width of all request ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of all data ports; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk, resetn.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 i_req_valid / i_req_addr  input  1 / ADDR_WIDTH  instruction-fetch read request.
REQ-007 i_addr_ok / i_data_ok / i_data  output  1 / 1 / DATA_WIDTH  fetch-side response.
REQ-008 d_req_valid / d_req_write / d_req_addr / d_req_strobe / d_req_wdata  input  1 / 1 / ADDR_WIDTH / DATA_WIDTH/8 / DATA_WIDTH  data request.
REQ-009 d_addr_ok / d_data_ok / d_data  output  1 / 1 / DATA_WIDTH  data-side response.
REQ-010 m_req_valid / m_req_write / m_req_addr / m_req_strobe / m_req_wdata  output  same widths as REQ-008  shared memory request.
REQ-011 m_addr_ok / m_data_ok / m_data  input  1 / 1 / DATA_WIDTH  shared memory response.

Function
REQ-012 SHALL run FSM states IDLE, ADDR, DATA; one outstanding memory transaction maximum.
REQ-013 IDLE: if any req_valid, SHALL latch grant (I or D) and go to ADDR next cycle; m_req_valid=0 in IDLE.
REQ-014 Arbitration latency: request first seen in IDLE at cycle N -> m_req_valid=1 at cycle N+1.
REQ-015 Default policy: D beats I when both valid in IDLE.
REQ-016 ADDR: m_req_* SHALL combinationally mirror granted requester's fields; fetch grant drives m_req_write=0, m_req_strobe=0, m_req_wdata=0.
REQ-017 ADDR: m_addr_ok SHALL pass combinationally to granted x_addr_ok; next state DATA.
REQ-018 ADDR with m_addr_ok and m_data_ok same cycle: SHALL forward both plus m_data same cycle; next state IDLE.
REQ-019 DATA: m_req_valid=0; m_data_ok/m_data SHALL pass to granted requester same cycle; next state IDLE.
REQ-020 Non-granted requester SHALL see addr_ok=0, data_ok=0, data=0 every cycle.
REQ-021 m_addr_ok/m_data_ok in IDLE, and m_addr_ok in DATA, SHALL be ignored (no forwarding, no state change).
REQ-022 Granted requester dropping req_valid in ADDR: m_req_valid follows to 0, FSM stays ADDR; grant unchanged.
REQ-023 Back-to-back: a request pending when returning to IDLE is granted in the IDLE cycle; minimum one IDLE cycle between transactions.

Reset
REQ-024 resetn low SHALL force IDLE, grant=I, last_grant=I, all outputs 0, asynchronously.
REQ-025 Reset mid-transaction SHALL abandon it; late m_data_ok after reset release in IDLE is dropped per REQ-021.

Configuration
REQ-026 Macro MEM_ARB_ROUND_ROBIN_EN: when defined, contested IDLE grant goes to the requester not in last_grant register (updated at each grant); reset last_grant=I, so first contest goes to D.
REQ-027 Without MEM_ARB_ROUND_ROBIN_EN: fixed priority per REQ-015; no last_grant register.

Verification
REQ-028 Fetch only: i_req_valid=1 addr 0x0000_0100 at cycle 0 -> m_req_valid=1 addr 0x100 write=0 at cycle 1; m_addr_ok cycle 2, m_data_ok data 0xDEAD_BEEF cycle 4 -> i_addr_ok cycle 2, i_data_ok/i_data=0xDEAD_BEEF cycle 4, d_* stay 0.
REQ-029 Contention, fixed priority: both valid cycle 0 (I 0x100, D write 0x200 strobe 0xF data 0x1234_5678) -> D served first, m_req_addr 0x200; I granted in IDLE after D completes.
REQ-030 Contention with MEM_ARB_ROUND_ROBIN_EN, both held valid across 4 transactions -> grant order D, I, D, I.
REQ-031 Same-cycle ok: m_addr_ok and m_data_ok both 1 in first ADDR cycle -> both forwarded that cycle, IDLE next cycle.
REQ-032 Reset in DATA: resetn low 1 cycle then high, then m_data_ok=1 -> no x_data_ok pulse, all outputs 0, state IDLE.
REQ-033 Spurious response: m_data_ok=1 while IDLE with no requests -> i/d data_ok remain 0, m_req_valid stays 0.
